rf_writeback_ctrl: RTL

- Write-side master for the 32x32 register file write port (wen/waddr/wdata).
- Merges single-cycle ALU results with out-of-order-latency load/long-op results, which are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against outstanding long-latency ops.

---
 rtl/rf_writeback_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: single write-port master for the 32x32 register file.
// Single-cycle ALU results take priority. Long-latency results wait in a small
// FIFO and drain whenever the ALU leaves the port free. A per-register pending
// scoreboard lets decode stall on RAW hazards against outstanding long ops.
module rf_writeback_ctrl #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_alu_valid,
    input  logic [4:0]                   i_alu_rd,
    input  logic [31:0]                  i_alu_data,
    input  logic                         i_lsu_valid,
    output logic                         o_lsu_ready,
    input  logic [4:0]                   i_lsu_rd,
    input  logic [31:0]                  i_lsu_data,
    input  logic                         i_issue_valid,
    input  logic [4:0]                   i_issue_rd,
    output logic [31:0]                  o_busy,
    output logic                         o_alu_stall,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_rd_wen,
    output logic [4:0]                   o_rd_waddr,
    output logic [31:0]                  o_rd_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [SW-1:0] starve_q;
    logic [31:0]   busy_q;
    logic [31:0]   busy_next;
    logic          alu_win;
    logic          fifo_ne;
    logic          push;
    logic          pop;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    // Arbitration, handshake and status outputs.
    always_comb begin
        alu_win     = i_alu_valid && (i_alu_rd != 5'd0);
        fifo_ne     = (count_q != '0);
        o_lsu_ready = !i_rst && (count_q < FULL_CNT);
        // Results targeting x0 are accepted but never stored.
        push        = i_lsu_valid && o_lsu_ready && (i_lsu_rd != 5'd0);
        pop         = fifo_ne && !alu_win;
        head_rd     = fifo_rd[rd_ptr];
        head_data   = fifo_data[rd_ptr];
        o_count     = count_q;
        o_busy      = busy_q;
        o_alu_stall = (starve_q == STARVE_MAX);
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= i_lsu_rd;
            fifo_data[wr_ptr] <= i_lsu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered write port: the winner of this cycle drives the RF next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_wen   <= 1'b0;
            o_rd_waddr <= '0;
            o_rd_wdata <= '0;
        end else if (alu_win) begin
            o_rd_wen   <= 1'b1;
            o_rd_waddr <= i_alu_rd;
            o_rd_wdata <= i_alu_data;
        end else if (pop) begin
            o_rd_wen   <= 1'b1;
            o_rd_waddr <= head_rd;
            o_rd_wdata <= head_data;
        end else begin
            o_rd_wen   <= 1'b0;
            o_rd_waddr <= '0;
            o_rd_wdata <= '0;
        end
    end

    // Scoreboard next state: clear on pop first so a same-cycle issue wins.
    always_comb begin
        busy_next = busy_q;
        if (pop) busy_next[head_rd] = 1'b0;
        if (i_issue_valid && (i_issue_rd != 5'd0)) busy_next[i_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge i_clk) begin
        if (i_rst) busy_q <= '0;
        else       busy_q <= busy_next;
    end

    // Starvation counter: counts ALU-blocked drain cycles, saturating.
    always_ff @(posedge i_clk) begin
        if (i_rst || !fifo_ne || pop) starve_q <= '0;
        else if (starve_q != STARVE_MAX) starve_q <= starve_q + SW'(1);
    end

endmodule
